spi_slave_regfile: RTL and testbench
====================================

# spi_slave_regfile

SPI mode-0 responder with a 16 x 8 register file. It is the target-side counterpart of the system's SPI master (SCK/MOSI/MISO/CS). Its first use is as an on-chip stand-in for the RFID reader front-end, so the master firmware can be exercised in simulation and on hardware loopback. It also serves as the slave port for the bike-rack sensor board. All SPI pins are oversampled in the `clk` domain; no SCK clock domain exists.

## Interface
Parameters:
- `ID_VALUE`, 8'hB1: constant returned by read-only register 0x0.
- `SYNC_STAGES`, 2: synchronizer depth on SCK, MOSI and CS (≥2).

Ports:
- `clk`  in  1: system clock; all logic on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `SCK`  in  1: SPI clock from master, idle low (CPOL=0).
- `MOSI`  in  1: master data, sampled on SCK rising edge, MSB first.
- `CS`  in  1: chip select, active low.
- `MISO`  out  1: slave data, changes after SCK falling edge, MSB first.
- `miso_oe`  out  1: high while CS is synchronized-low; enables the pad driver.
- `wr_stb`  out  1: one-cycle pulse when an SPI write commits.
- `wr_addr`  out  4: address of the committed write; valid with `wr_stb`.
- `wr_data`  out  8: data of the committed write; valid with `wr_stb`.
- `loc_we`  in  1: local (fabric) write enable.
- `loc_addr`  in  4: local read/write address.
- `loc_wdata`  in  8: local write data.
- `loc_rdata`  out  8: registered read of `reg[loc_addr]`, 1-cycle latency.

## Operation
- **Frame.** CS low, then an address byte, then N≥0 data bytes, then CS high.
- **Address byte.** Bit7 = 1 selects read, 0 selects write. Bits6:4 are ignored. Bits3:0 set the start pointer.
- **States.**
  - IDLE: CS high. Goes to ADDR on CS falling.
  - ADDR: shift 8 bits. On the 8th rising edge, latch R/W and pointer, then go to DATA.
  - DATA: loop on bytes.
  - Any state goes to IDLE when CS goes high.
- **Write.** On the 8th rising edge of each data byte:
  - If pointer ≠ 0, write `reg[ptr]` and pulse `wr_stb` with `wr_addr`/`wr_data`.
  - If pointer = 0 (read-only), no write and no strobe.
  - Pointer then increments.
- **Read.** On completion of the address byte and of every data byte, load `tx_byte = reg[ptr]` (or `ID_VALUE` at 0) and increment the pointer. MOSI content of read data bytes is ignored.
- **Pointer.** 4-bit and wraps 15 → 0. Bursts past 0xF continue at 0x0.
- **MISO sequence.**
  - During the address byte MISO = 0.
  - On each SCK falling edge: at a byte boundary (bit counter = 0), drive `tx_byte[7]` and load the shifter with `tx_byte<<1`. Otherwise drive `shifter[7]` and shift left.
  - In write frames MISO stays 0.
- **Abort.** CS high mid-byte discards the partial byte: no write, no strobe, bit counter cleared, MISO = 0.
- **Collision.** SPI commit and `loc_we` to the same address in the same cycle: the SPI value is stored and the local write is dropped. Writes to different addresses both commit. `loc_we` to 0x0 is ignored.
- **Reset values.** regs 1–15 = 0x00; MISO = 0; `miso_oe` = 0; `wr_stb` = 0; `wr_addr` = 0; `wr_data` = 0; `loc_rdata` = 0; state IDLE; pointer 0; bit counter 0.
- **Reset mid-frame.** Same as reset. After reset deasserts, the block waits for a fresh CS falling edge before accepting bits.

## Timing
- Pin to detected edge takes `SYNC_STAGES` + 1 clk. MISO updates 1 clk after the detected falling edge: 4 clk total with the default depth.
- SCK high and low times must each be ≥ `SYNC_STAGES` + 3 clk, i.e. 5 clk by default. At 100 MHz this gives SCK ≤ 10 MHz.
- CS falling to first SCK rising edge must be ≥ `SYNC_STAGES` + 2 clk. CS rising after the last SCK falling edge must be ≥ 2 clk.
- `wr_stb` asserts `SYNC_STAGES` + 2 clk after the 8th SCK rising pin edge of the byte and lasts exactly 1 clk.
- `miso_oe` follows synchronized CS; it lags the CS pin by `SYNC_STAGES` clk.
- `loc_rdata` reflects `loc_addr` from the previous cycle, including a write committed in that previous cycle.

## Test plan
- Reset, then frame 0x80,0x00 → MISO byte 2 = 0xB1, byte 1 = 0x00; `miso_oe` high only while CS is low.
- Frame 0x05,0xA5 → exactly one `wr_stb`, `wr_addr`=5, `wr_data`=0xA5. Then frame 0x85,0x00 → MISO byte 2 = 0xA5, and `loc_rdata` at addr 5 = 0xA5.
- Burst 0x0F,0x11,0x22,0x33 → reg15 = 0x11, reg0 unchanged (no strobe), reg1 = 0x33. Then read burst 0x8F,x,x,x → 0x11, 0xB1, 0x33.
- Frame 0x03, then 5 data bits, then CS high → no `wr_stb`, reg3 = 0x00. Next frame 0x03,0x5A → reg3 = 0x5A.
- SPI write 0x07←0x3C commits in the same cycle as `loc_we` addr 7 data 0xFF → reg7 = 0x3C. `loc_we` addr 8 in the same cycle → reg8 = 0xFF.
- Assert `rst` mid-byte during a write burst → all outputs return to reset values and regs 1–15 clear. A subsequent full frame 0x02,0x44 → reg2 = 0x44.

Source files
------------

// File: rtl/spi_slave_regfile.sv
// SPI mode-0 responder backed by a 16x8 register file.
// SPI pins are oversampled in clk; reg 0 reads back ID_VALUE.
module spi_slave_regfile #(
  parameter logic [7:0] ID_VALUE = 8'hB1,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       SCK,
  input  logic       MOSI,
  input  logic       CS,
  output logic       MISO,
  output logic       miso_oe,
  output logic       wr_stb,
  output logic [3:0] wr_addr,
  output logic [7:0] wr_data,
  input  logic       loc_we,
  input  logic [3:0] loc_addr,
  input  logic [7:0] loc_wdata,
  output logic [7:0] loc_rdata
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] vld;
  logic sck_s, mosi_s, cs_s;
  logic sck_q, sck_rise, sck_fall;

  state_t     state;
  logic [2:0] bit_cnt;
  logic [6:0] rx;
  logic [3:0] ptr;
  logic       rd;
  logic       cs_hi_seen;
  logic [7:0] tx_byte;
  logic [7:0] tx_shift;
  logic [7:0] regs [16];

  logic [7:0] rx_byte;
  logic       spi_commit;
  logic       loc_commit;
  logic [7:0] loc_next;

  assign sck_s   = sck_sync[SYNC_STAGES-1];
  assign mosi_s  = mosi_sync[SYNC_STAGES-1];
  assign cs_s    = cs_sync[SYNC_STAGES-1];
  assign miso_oe = ~cs_s;

  // CS chain resets high so the pad stays disabled until real samples arrive.
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync  <= '0;
      mosi_sync <= '0;
      cs_sync   <= '1;
      vld       <= '0;
      sck_q     <= 1'b0;
      sck_rise  <= 1'b0;
      sck_fall  <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], SCK};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], CS};
      vld       <= {vld[SYNC_STAGES-2:0], 1'b1};
      sck_q     <= sck_s;
      sck_rise  <= sck_s & ~sck_q;
      sck_fall  <= ~sck_s & sck_q;
    end
  end

  function automatic logic [7:0] rd_val(input logic [3:0] a);
    return (a == 4'd0) ? ID_VALUE : regs[a];
  endfunction

  assign rx_byte = {rx, mosi_s};

  assign spi_commit = !cs_s && state == DATA && sck_rise &&
                      bit_cnt == 3'd7 && !rd && ptr != 4'd0;

  assign loc_commit = loc_we && loc_addr != 4'd0 &&
                      !(spi_commit && ptr == loc_addr);

  always_comb begin
    loc_next = rd_val(loc_addr);
    if (loc_commit)
      loc_next = loc_wdata;
    if (spi_commit && ptr == loc_addr)
      loc_next = rx_byte;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++)
        regs[i] <= 8'h00;
    end else begin
      if (loc_commit)
        regs[loc_addr] <= loc_wdata;
      if (spi_commit)
        regs[ptr] <= rx_byte;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= 3'd0;
      rx         <= 7'd0;
      ptr        <= 4'd0;
      rd         <= 1'b0;
      cs_hi_seen <= 1'b0;
      tx_byte    <= 8'h00;
      tx_shift   <= 8'h00;
      MISO       <= 1'b0;
      wr_stb     <= 1'b0;
      wr_addr    <= 4'd0;
      wr_data    <= 8'h00;
      loc_rdata  <= 8'h00;
    end else begin
      wr_stb    <= spi_commit;
      loc_rdata <= loc_next;
      if (spi_commit) begin
        wr_addr <= ptr;
        wr_data <= rx_byte;
      end
      if (cs_s) begin
        state   <= IDLE;
        bit_cnt <= 3'd0;
        MISO    <= 1'b0;
        if (vld[SYNC_STAGES-1])
          cs_hi_seen <= 1'b1;
      end else begin
        unique case (state)
          IDLE: begin
            // only a genuine high-to-low CS transition opens a frame
            if (cs_hi_seen) begin
              state      <= ADDR;
              cs_hi_seen <= 1'b0;
              bit_cnt    <= 3'd0;
              MISO       <= 1'b0;
            end
          end
          ADDR: begin
            if (sck_rise) begin
              rx      <= rx_byte[6:0];
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                state <= DATA;
                rd    <= rx_byte[7];
                if (rx_byte[7]) begin
                  tx_byte <= rd_val(rx_byte[3:0]);
                  ptr     <= rx_byte[3:0] + 4'd1;
                end else begin
                  ptr <= rx_byte[3:0];
                end
              end
            end
          end
          DATA: begin
            if (sck_rise) begin
              rx      <= rx_byte[6:0];
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                ptr <= ptr + 4'd1;
                if (rd)
                  tx_byte <= rd_val(ptr);
              end
            end
            if (sck_fall && rd) begin
              if (bit_cnt == 3'd0) begin
                MISO     <= tx_byte[7];
                tx_shift <= {tx_byte[6:0], 1'b0};
              end else begin
                MISO     <= tx_shift[7];
                tx_shift <= {tx_shift[6:0], 1'b0};
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Scoreboard bench for spi_slave_regfile: a register model predicts
// MISO bytes and write strobes, queued at stimulus time.
module tb_spi_slave_regfile;

  localparam logic [7:0] ID = 8'hB1;

  logic       clk = 1'b0;
  logic       rst;
  logic       SCK, MOSI, CS;
  logic       MISO, miso_oe, wr_stb;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       loc_we;
  logic [3:0] loc_addr;
  logic [7:0] loc_wdata;
  logic [7:0] loc_rdata;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]  exp_miso [$];
  logic [11:0] exp_wr [$];
  logic [7:0]  model [16];
  logic [7:0]  fbuf [8];
  logic [3:0]  coll_addr;
  logic [7:0]  coll_data;
  logic [11:0] mon_e;
  logic        dummy_b;

  spi_slave_regfile #(.ID_VALUE(ID), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .SCK(SCK), .MOSI(MOSI), .CS(CS),
    .MISO(MISO), .miso_oe(miso_oe), .wr_stb(wr_stb),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .loc_we(loc_we), .loc_addr(loc_addr), .loc_wdata(loc_wdata),
    .loc_rdata(loc_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] mval(input logic [3:0] a);
    return (a == 4'd0) ? ID : model[a];
  endfunction

  always @(negedge clk) begin
    if (!rst && wr_stb) begin
      if (exp_wr.size() == 0) begin
        chk("wr_stb_unexpected", {31'd0, wr_stb}, 32'd0);
      end else begin
        mon_e = exp_wr.pop_front();
        chk("wr_addr", {28'd0, wr_addr}, {28'd0, mon_e[11:8]});
        chk("wr_data", {24'd0, wr_data}, {24'd0, mon_e[7:0]});
      end
    end
  end

  task automatic spi_bit(input logic b, input bit coll, output logic r);
    MOSI = b;
    repeat (6) @(negedge clk);
    r = MISO;
    SCK = 1'b1;
    repeat (3) @(negedge clk);
    if (coll) begin
      loc_we    = 1'b1;
      loc_addr  = coll_addr;
      loc_wdata = coll_data;
    end
    @(negedge clk);
    loc_we = 1'b0;
    repeat (2) @(negedge clk);
    SCK = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] tx, input bit coll);
    logic [7:0] r;
    logic b;
    r = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], coll && (i == 0), b);
      r[i] = b;
    end
    chk("miso_oe_active", {31'd0, miso_oe}, 32'd1);
    if (exp_miso.size() == 0)
      chk("miso_queue_empty", exp_miso.size(), 32'd1);
    else
      chk("miso_byte", {24'd0, r}, {24'd0, exp_miso.pop_front()});
  endtask

  task automatic spi_frame(input int n, input int coll_idx);
    logic       rdf;
    logic [3:0] p;
    rdf = fbuf[0][7];
    p   = fbuf[0][3:0];
    exp_miso.push_back(8'h00);
    for (int k = 1; k < n; k++) begin
      if (rdf) begin
        exp_miso.push_back(mval(p));
      end else begin
        exp_miso.push_back(8'h00);
        if (p != 4'd0) begin
          exp_wr.push_back({p, fbuf[k]});
          model[p] = fbuf[k];
        end
      end
      p = p + 4'd1;
    end
    CS = 1'b0;
    for (int k = 0; k < n; k++)
      spi_byte(fbuf[k], k == coll_idx);
    repeat (3) @(negedge clk);
    CS = 1'b1;
    repeat (8) @(negedge clk);
    chk("miso_oe_idle", {31'd0, miso_oe}, 32'd0);
    chk("miso_idle", {31'd0, MISO}, 32'd0);
  endtask

  task automatic loc_read(input logic [3:0] a, input logic [7:0] exp);
    loc_addr = a;
    @(negedge clk);
    chk("loc_rdata", {24'd0, loc_rdata}, {24'd0, exp});
  endtask

  task automatic loc_write(input logic [3:0] a, input logic [7:0] d);
    loc_we    = 1'b1;
    loc_addr  = a;
    loc_wdata = d;
    @(negedge clk);
    loc_we = 1'b0;
    if (a != 4'd0)
      model[a] = d;
  endtask

  task automatic chk_reset_outs();
    chk("rst_miso", {31'd0, MISO}, 32'd0);
    chk("rst_miso_oe", {31'd0, miso_oe}, 32'd0);
    chk("rst_wr_stb", {31'd0, wr_stb}, 32'd0);
    chk("rst_wr_addr", {28'd0, wr_addr}, 32'd0);
    chk("rst_wr_data", {24'd0, wr_data}, 32'd0);
    chk("rst_loc_rdata", {24'd0, loc_rdata}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; SCK = 1'b0; MOSI = 1'b0; CS = 1'b1;
    loc_we = 1'b0; loc_addr = 4'd0; loc_wdata = 8'h00;
    coll_addr = 4'd0; coll_data = 8'h00;
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    repeat (4) @(negedge clk);
    chk_reset_outs();
    rst = 1'b0;
    repeat (6) @(negedge clk);

    fbuf[0] = 8'h80; fbuf[1] = 8'h00;
    spi_frame(2, -1);

    fbuf[0] = 8'h05; fbuf[1] = 8'hA5;
    spi_frame(2, -1);
    fbuf[0] = 8'h85; fbuf[1] = 8'h00;
    spi_frame(2, -1);
    loc_read(4'd5, 8'hA5);

    fbuf[0] = 8'h0F; fbuf[1] = 8'h11; fbuf[2] = 8'h22; fbuf[3] = 8'h33;
    spi_frame(4, -1);
    loc_read(4'd15, 8'h11);
    loc_read(4'd0, ID);
    loc_read(4'd1, 8'h33);
    fbuf[0] = 8'h8F; fbuf[1] = 8'h00; fbuf[2] = 8'h00; fbuf[3] = 8'h00;
    spi_frame(4, -1);

    exp_miso.push_back(8'h00);
    CS = 1'b0;
    spi_byte(8'h03, 1'b0);
    for (int i = 0; i < 5; i++)
      spi_bit(1'b1, 1'b0, dummy_b);
    repeat (3) @(negedge clk);
    CS = 1'b1;
    repeat (8) @(negedge clk);
    chk("abort_miso", {31'd0, MISO}, 32'd0);
    loc_read(4'd3, 8'h00);
    fbuf[0] = 8'h03; fbuf[1] = 8'h5A;
    spi_frame(2, -1);
    loc_read(4'd3, 8'h5A);

    coll_addr = 4'd7; coll_data = 8'hFF;
    fbuf[0] = 8'h07; fbuf[1] = 8'h3C;
    spi_frame(2, 1);
    loc_read(4'd7, 8'h3C);
    coll_addr = 4'd8; coll_data = 8'hFF;
    fbuf[0] = 8'h07; fbuf[1] = 8'h3C;
    spi_frame(2, 1);
    model[8] = 8'hFF;
    loc_read(4'd8, 8'hFF);
    loc_read(4'd7, 8'h3C);

    loc_write(4'd0, 8'h55);
    loc_read(4'd0, ID);
    loc_write(4'd9, 8'h77);
    loc_read(4'd9, 8'h77);

    exp_miso.push_back(8'h00);
    exp_miso.push_back(8'h00);
    exp_wr.push_back({4'd1, 8'h11});
    CS = 1'b0;
    spi_byte(8'h01, 1'b0);
    spi_byte(8'h11, 1'b0);
    for (int i = 0; i < 3; i++)
      spi_bit(1'b1, 1'b0, dummy_b);
    rst = 1'b1;
    SCK = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outs();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    repeat (6) @(negedge clk);
    CS = 1'b1;
    repeat (8) @(negedge clk);
    loc_read(4'd9, 8'h00);
    loc_read(4'd1, 8'h00);
    loc_read(4'd15, 8'h00);
    fbuf[0] = 8'h02; fbuf[1] = 8'h44;
    spi_frame(2, -1);
    loc_read(4'd2, 8'h44);
    fbuf[0] = 8'h82; fbuf[1] = 8'h00;
    spi_frame(2, -1);

    chk("wr_pending", exp_wr.size(), 32'd0);
    chk("miso_pending", exp_miso.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
